user_id_reader: RTL and testbench

USER_ID_READER -- requirements
Module: user_id_reader

---
 rtl/user_id_pkg.sv | 18 +
 rtl/user_id_ser_tick.sv | 35 +++
 rtl/user_id_reader.sv | 141 ++++++++++++++
 tb/tb_user_id_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_id_pkg.sv
// Shared types and default parameters for the user project ID reader.
// The FSM state encoding lives here so the top and the bench agree on it.
package user_id_pkg;

    localparam int DEF_ID_WIDTH  = 32;
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_MAX_RETRY = 3;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE_A,
        SAMPLE_B,
        SHIFT,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/user_id_ser_tick.sv
// Serial bit timer: divides the system clock into CLK_DIV-cycle bits,
// producing the serial clock level and a strobe on each bit's last cycle.
module user_id_ser_tick
    import user_id_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic ser_clk,
    output logic bit_end
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_q;

    assign bit_end = en & (div_q == LAST);
    assign ser_clk = en & (div_q >= HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (clr || bit_end) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/user_id_reader.sv
// Reads the tie-cell project ID twice until two samples agree, then
// shifts the verified value out MSB first on a divided serial clock.
module user_id_reader
    import user_id_pkg::*;
#(
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic [ID_WIDTH-1:0] mask_rev_i,
    input  logic                sample_req_i,
    output logic                busy_o,
    output logic [ID_WIDTH-1:0] id_o,
    output logic                id_valid_o,
    output logic                id_err_o,
    output logic                ser_clk_o,
    output logic                ser_data_o,
    output logic                ser_done_o
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int BW = $clog2(ID_WIDTH);

    state_t state_q, state_d;

    logic [ID_WIDTH-1:0] shadow_a;
    logic [ID_WIDTH-1:0] shadow_b;
    logic [ID_WIDTH-1:0] id_q;
    logic                valid_q;
    logic                err_q;
    logic [RW-1:0]       retry_q;
    logic [BW-1:0]       bit_q;

    logic shift_en;
    logic load;
    logic match;
    logic last_retry;
    logic last_bit;
    logic tick_clk;
    logic bit_end;

    assign match      = (shadow_a == mask_rev_i);
    assign last_retry = (retry_q == RW'(MAX_RETRY - 1));
    assign last_bit   = (bit_q == BW'(ID_WIDTH - 1));
    assign load       = (state_q == SAMPLE_B) & match;

    user_id_ser_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (wb_clk_i),
        .rst_n  (wb_rstn_i),
        .en     (shift_en),
        .clr    (load),
        .ser_clk(tick_clk),
        .bit_end(bit_end)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (sample_req_i) state_d = SAMPLE_A;
            SAMPLE_A: state_d = SAMPLE_B;
            SAMPLE_B: begin
                if (match)           state_d = SHIFT;
                else if (last_retry) state_d = ERROR;
                else                 state_d = SAMPLE_A;
            end
            SHIFT:    if (bit_end && last_bit) state_d = DONE;
            DONE:     state_d = IDLE;
            ERROR:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        shift_en   = (state_q == SHIFT);
        ser_done_o = (state_q == DONE);
    end

    // shadow_b doubles as the shift register once the samples agree
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            shadow_a <= '0;
            shadow_b <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            retry_q  <= '0;
            bit_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sample_req_i) begin
                        retry_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                SAMPLE_A: shadow_a <= mask_rev_i;
                SAMPLE_B: begin
                    shadow_b <= mask_rev_i;
                    if (match) begin
                        id_q    <= mask_rev_i;
                        valid_q <= 1'b1;
                        bit_q   <= '0;
                    end else begin
                        retry_q <= retry_q + RW'(1);
                        if (last_retry) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        shadow_b <= shadow_b << 1;
                        if (!last_bit) bit_q <= bit_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign id_o       = id_q;
    assign id_valid_o = valid_q;
    assign id_err_o   = err_q;
    assign ser_clk_o  = tick_clk;
    assign ser_data_o = shift_en & shadow_b[ID_WIDTH-1];

endmodule

// File: tb/tb_user_id_reader.sv
// Directed bench for user_id_reader: default instance plus a CLK_DIV=2
// instance, with per-scenario tasks checking latency and serial content.
module tb_user_id_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mask, mask2;
    logic        req, req2;
    logic        busy, valid, err, sclk, sdata, done;
    logic [31:0] id;
    logic        busy2, valid2, err2, sclk2, sdata2, done2;
    logic [31:0] id2;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int errors = 0;

    int          done_cnt, done_cyc, rise_cnt, data_bad;
    logic [31:0] bits;
    logic        pclk, pdata;
    int          done_cnt2, done_cyc2, rise_cnt2, period_bad, last_rise;
    logic        pclk2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    user_id_reader dut (
        .wb_clk_i    (clk),
        .wb_rstn_i   (rst_n),
        .mask_rev_i  (mask),
        .sample_req_i(req),
        .busy_o      (busy),
        .id_o        (id),
        .id_valid_o  (valid),
        .id_err_o    (err),
        .ser_clk_o   (sclk),
        .ser_data_o  (sdata),
        .ser_done_o  (done)
    );

    user_id_reader #(.CLK_DIV(2)) dut2 (
        .wb_clk_i    (clk),
        .wb_rstn_i   (rst_n),
        .mask_rev_i  (mask2),
        .sample_req_i(req2),
        .busy_o      (busy2),
        .id_o        (id2),
        .id_valid_o  (valid2),
        .id_err_o    (err2),
        .ser_clk_o   (sclk2),
        .ser_data_o  (sdata2),
        .ser_done_o  (done2)
    );

    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc - base;
        end
        if (sclk && !pclk) begin
            rise_cnt = rise_cnt + 1;
            bits = {bits[30:0], sdata};
        end
        if (sclk && pclk && sdata != pdata) data_bad = data_bad + 1;
        pclk  = sclk;
        pdata = sdata;
        if (done2) begin
            done_cnt2 = done_cnt2 + 1;
            done_cyc2 = cyc - base;
        end
        if (sclk2 && !pclk2) begin
            if (rise_cnt2 > 0 && cyc - last_rise != 2) period_bad = period_bad + 1;
            rise_cnt2 = rise_cnt2 + 1;
            last_rise = cyc;
        end
        if (sclk2 && pclk2) period_bad = period_bad + 1;
        pclk2 = sclk2;
    end

    task automatic clr_mon();
        done_cnt = 0; done_cyc = -1; rise_cnt = 0; data_bad = 0; bits = '0;
        done_cnt2 = 0; done_cyc2 = -1; rise_cnt2 = 0; period_bad = 0; last_rise = 0;
    endtask

    task automatic start_req();
        @(negedge clk);
        req  = 1'b1;
        base = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_rel(input int k);
        while (cyc - base < k) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: no ser_done_o within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; req2 = 1'b0; mask = '0; mask2 = '0;
        clr_mon();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, id, valid, err, sclk, sdata, done} !== 38'd0) begin
            errors++;
            $display("FAIL reset_out: got %h exp 0", {busy, id, valid, err, sclk, sdata, done});
        end
        checks++;
        if ({busy2, id2, valid2, err2, sclk2, sdata2, done2} !== 38'd0) begin
            errors++;
            $display("FAIL reset_out2: got %h exp 0", {busy2, id2, valid2, err2, sclk2, sdata2, done2});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        clr_mon();
        mask = 32'hA5A5_0F0F;
        start_req();
        wait_rel(2);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_c2: busy=%b valid=%b exp 1 0", busy, valid);
        end
        wait_rel(3);
        checks++;
        if (id !== 32'hA5A5_0F0F || valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_c3: id=%h valid=%b exp a5a50f0f 1", id, valid);
        end
        wait_done("basic", 300);
        checks++;
        if (done_cyc != 131) begin
            errors++;
            $display("FAIL basic_done_cyc: got %0d exp 131", done_cyc);
        end
        checks++;
        if (bits !== 32'hA5A5_0F0F || rise_cnt != 32) begin
            errors++;
            $display("FAIL basic_bits: got %h/%0d exp a5a50f0f/32", bits, rise_cnt);
        end
        checks++;
        if (data_bad != 0) begin
            errors++;
            $display("FAIL basic_data_stable: got %0d changes exp 0", data_bad);
        end
        wait_rel(133);
        checks++;
        if (busy !== 1'b0 || sclk !== 1'b0 || done !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_idle: busy=%b sclk=%b done=%b cnt=%0d exp 0 0 0 1",
                     busy, sclk, done, done_cnt);
        end
    endtask

    task automatic test_retry();
        clr_mon();
        mask = 32'h0;
        start_req();
        wait_rel(1);
        checks++;
        if (id !== 32'hA5A5_0F0F || valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL retry_hold: id=%h valid=%b busy=%b exp a5a50f0f 1 1", id, valid, busy);
        end
        @(negedge clk);
        mask = 32'h1234_5678;
        wait_rel(4);
        checks++;
        if (id !== 32'hA5A5_0F0F || sclk !== 1'b0) begin
            errors++;
            $display("FAIL retry_c4: id=%h sclk=%b exp a5a50f0f 0", id, sclk);
        end
        wait_rel(5);
        checks++;
        if (id !== 32'h1234_5678 || valid !== 1'b1) begin
            errors++;
            $display("FAIL retry_c5: id=%h valid=%b exp 12345678 1", id, valid);
        end
        wait_done("retry", 300);
        checks++;
        if (done_cyc != 133 || bits !== 32'h1234_5678) begin
            errors++;
            $display("FAIL retry_done: cyc=%0d bits=%h exp 133 12345678", done_cyc, bits);
        end
        wait_rel(136);
    endtask

    task automatic test_error();
        clr_mon();
        @(negedge clk);
        mask = 32'h0;
        req  = 1'b1;
        base = cyc;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req  = 1'b0;
            mask = ~mask;
            if (i == 7) begin
                #1;
                checks++;
                if (err !== 1'b1 || busy !== 1'b1 || valid !== 1'b0) begin
                    errors++;
                    $display("FAIL err_c7: err=%b busy=%b valid=%b exp 1 1 0", err, busy, valid);
                end
            end
        end
        #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL err_c8: busy=%b err=%b valid=%b exp 0 1 0", busy, err, valid);
        end
        checks++;
        if (id !== 32'h1234_5678) begin
            errors++;
            $display("FAIL err_id_hold: got %h exp 12345678", id);
        end
        checks++;
        if (rise_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL err_no_ser: rises=%0d dones=%0d exp 0 0", rise_cnt, done_cnt);
        end
        mask = 32'h0;
    endtask

    task automatic test_ignore_req();
        clr_mon();
        mask = 32'hCAFE_F00D;
        start_req();
        wait_rel(1);
        checks++;
        if (err !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_clear: err=%b valid=%b exp 0 0", err, valid);
        end
        wait_rel(13);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_rel(53);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done("ignore", 300);
        checks++;
        if (done_cyc != 131 || bits !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL ign_done: cyc=%0d bits=%h exp 131 cafef00d", done_cyc, bits);
        end
        wait_rel(145);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_single: dones=%0d busy=%b exp 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_shift();
        clr_mon();
        mask = 32'h0F0F_0F0F;
        start_req();
        wait_rel(32);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, id, valid, err, sclk, sdata, done} !== 38'd0) begin
            errors++;
            $display("FAIL rst_shift_out: got %h exp 0", {busy, id, valid, err, sclk, sdata, done});
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL rst_shift_nodone: got %0d exp 0", done_cnt);
        end
        rst_n = 1'b1;
        clr_mon();
        mask = 32'h89AB_CDEF;
        start_req();
        wait_done("rst_again", 300);
        checks++;
        if (done_cyc != 131 || bits !== 32'h89AB_CDEF || id !== 32'h89AB_CDEF) begin
            errors++;
            $display("FAIL rst_again: cyc=%0d bits=%h id=%h exp 131 89abcdef 89abcdef",
                     done_cyc, bits, id);
        end
        wait_rel(134);
    endtask

    task automatic test_div2();
        int n = 0;
        clr_mon();
        mask2 = 32'h0;
        @(negedge clk);
        req2 = 1'b1;
        base = cyc;
        @(negedge clk);
        req2 = 1'b0;
        while (done_cnt2 == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (done_cyc2 != 67) begin
            errors++;
            $display("FAIL div2_done_cyc: got %0d exp 67", done_cyc2);
        end
        checks++;
        if (rise_cnt2 != 32 || period_bad != 0) begin
            errors++;
            $display("FAIL div2_period: rises=%0d bad=%0d exp 32 0", rise_cnt2, period_bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_retry();
        test_error();
        test_ignore_req();
        test_reset_shift();
        test_div2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
